// File: rtl/pdm_cic_decimator.sv
// 3rd-order CIC decimator turning a 1-bit PDM stream into signed PCM samples.
// Define PDM_CIC_SAT_EN to clamp the output instead of wrapping positive full scale.
module pdm_cic_decimator #(
   parameter int WIDTH = 16,
   parameter int DECIM = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pdm_en,
   input  logic                    pdm_in,
   output logic signed [WIDTH-1:0] pcm_out,
   output logic                    pcm_valid
);

   localparam int L  = $clog2(DECIM);
   localparam int G  = 3 * L + 2;
   localparam int SH = 3 * L + 1 - WIDTH;

   logic signed [G-1:0] i1, i2, i3;
   logic signed [G-1:0] d1, d2, d3;
   logic        [L-1:0] cnt;
   logic                dec_tick;

   logic signed [G-1:0]     x;
   logic signed [G-1:0]     i1_n, i2_n, i3_n;
   logic signed [G-1:0]     c1, c2, c3;
   logic signed [G-1:0]     shifted;
   logic signed [WIDTH-1:0] pcm_n;

`ifdef PDM_CIC_SAT_EN
   localparam logic signed [G-1:0] MAXV = G'({1'b0, {(WIDTH-1){1'b1}}});
   localparam logic signed [G-1:0] MINV = ~MAXV;
`endif

   // Integrators cascade within one strobe: each stage sees the freshly updated one before it.
   always_comb begin
      x    = pdm_in ? {{(G-1){1'b0}}, 1'b1} : '1;
      i1_n = i1 + x;
      i2_n = i2 + i1_n;
      i3_n = i3 + i2_n;
   end

   // Combs run on the registered I3, so a strobe on the same edge is not yet included.
   always_comb begin
      c1      = i3 - d1;
      c2      = c1 - d2;
      c3      = c2 - d3;
      shifted = c3 >>> SH;
`ifdef PDM_CIC_SAT_EN
      if (shifted > MAXV)
         pcm_n = {1'b0, {(WIDTH-1){1'b1}}};
      else if (shifted < MINV)
         pcm_n = {1'b1, {(WIDTH-1){1'b0}}};
      else
         pcm_n = WIDTH'(shifted);
`else
      pcm_n = WIDTH'(shifted);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i1        <= '0;
         i2        <= '0;
         i3        <= '0;
         d1        <= '0;
         d2        <= '0;
         d3        <= '0;
         cnt       <= '0;
         dec_tick  <= 1'b0;
         pcm_out   <= '0;
         pcm_valid <= 1'b0;
      end else begin
         if (pdm_en) begin
            i1  <= i1_n;
            i2  <= i2_n;
            i3  <= i3_n;
            cnt <= cnt + 1'b1;
         end
         dec_tick  <= pdm_en && (cnt == '1);
         pcm_valid <= dec_tick;
         if (dec_tick) begin
            d1      <= i3;
            d2      <= c1;
            d3      <= c2;
            pcm_out <= pcm_n;
         end
      end
   end

endmodule
